// File: rtl/bus_arbiter_pkg.sv
// ==================================================================
// bus_arbiter_pkg : arbiter state encoding and index sizing   rev 1.0
// ==================================================================
`default_nettype none

package bus_arbiter_pkg;

   localparam int MAX_MASTERS = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_e;

   // Width of a master index; a single master still needs one select bit.
   function automatic int msel_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_rr_picker.sv
// ==================================================================
// rr_picker : combinational round-robin winner search          rev 1.0
// ==================================================================
`default_nettype none

module rr_picker #(
   parameter int NUM_MASTERS = 2,
   parameter int MSEL_WIDTH  = 1
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [MSEL_WIDTH-1:0]  last,
   output logic [MSEL_WIDTH-1:0]  winner,
   output logic                   any
);

   int                     idx;
   logic [NUM_MASTERS-1:0] shifted;

   // Scan last+1, last+2, ... wrapping, so the previous owner is checked last.
   always_comb begin
      winner  = '0;
      any     = 1'b0;
      idx     = 0;
      shifted = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         idx     = (int'(last) + k) % NUM_MASTERS;
         shifted = req >> idx;
         if (!any && shifted[0]) begin
            any    = 1'b1;
            winner = MSEL_WIDTH'(idx);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ==================================================================
// bus_arbiter : round-robin bus arbiter with master-side mux   rev 1.0
// ==================================================================
`default_nettype none

module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int MSEL_WIDTH  = 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NUM_MASTERS-1:0] mbreq,
   output logic [NUM_MASTERS-1:0] mbgrant,
   input  logic [NUM_MASTERS-1:0] mwdata,
   input  logic [NUM_MASTERS-1:0] mmode,
   input  logic [NUM_MASTERS-1:0] mvalid,
   output logic [NUM_MASTERS-1:0] mrdata,
   output logic [NUM_MASTERS-1:0] msvalid,
   output logic                   bwdata,
   output logic                   bmode,
   output logic                   bvalid,
   input  logic                   brdata,
   input  logic                   bsvalid,
   output logic [MSEL_WIDTH-1:0]  bmsel,
   output logic                   bbusy
);

   arb_state_e             state_q, state_d;
   logic [MSEL_WIDTH-1:0]  last_q, last_d;
   logic [MSEL_WIDTH-1:0]  bmsel_q, bmsel_d;
   logic [NUM_MASTERS-1:0] mbgrant_q, mbgrant_d;
   logic [MSEL_WIDTH-1:0]  pick_idx;
   logic                   pick_any;
   logic                   owner_active;

   rr_picker #(
      .NUM_MASTERS (NUM_MASTERS),
      .MSEL_WIDTH  (MSEL_WIDTH)
   ) u_picker (
      .req    (mbreq),
      .last   (last_q),
      .winner (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      bmsel_d   = bmsel_q;
      mbgrant_d = mbgrant_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               state_d   = ST_GRANT;
               bmsel_d   = pick_idx;
               last_d    = pick_idx;
               mbgrant_d = NUM_MASTERS'(1) << pick_idx;
            end
         end
         ST_GRANT: begin
            if (!mbreq[bmsel_q]) begin
               state_d   = ST_RELEASE;
               mbgrant_d = '0;
            end
         end
         ST_RELEASE: state_d = ST_IDLE;
         default: begin
            state_d   = ST_IDLE;
            mbgrant_d = '0;
         end
      endcase
   end

   // Pointer resets to the top index so master 0 wins the first arbitration.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         last_q    <= MSEL_WIDTH'(NUM_MASTERS - 1);
         bmsel_q   <= '0;
         mbgrant_q <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         bmsel_q   <= bmsel_d;
         mbgrant_q <= mbgrant_d;
      end
   end

   assign owner_active = (state_q == ST_GRANT);

   always_comb begin
      bwdata  = owner_active & mwdata[bmsel_q];
      bmode   = owner_active & mmode[bmsel_q];
      bvalid  = owner_active & mvalid[bmsel_q];
      mrdata  = '0;
      msvalid = '0;
      if (owner_active) begin
         mrdata[bmsel_q]  = brdata;
         msvalid[bmsel_q] = bsvalid;
      end
   end

   assign mbgrant = mbgrant_q;
   assign bmsel   = bmsel_q;
   assign bbusy   = owner_active;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ==================================================================
// tb_bus_arbiter : scoreboard bench for 2- and 4-master arbiters  rev 1.0
// ==================================================================
`default_nettype none

module tb_bus_arbiter;

   typedef struct {
      int idx;
      int cyc;
   } sb_t;

   logic clk = 1'b0;
   logic rstn;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   sb_t  q2[$];
   sb_t  q4[$];
   sb_t  e2, e4;

   logic [1:0] mbreq2, mwdata2, mmode2, mvalid2, mbgrant2, mrdata2, msvalid2;
   logic       brdata2, bsvalid2, bwdata2, bmode2, bvalid2, bbusy2;
   logic [0:0] bmsel2;
   logic [1:0] prev2 = '0;

   logic [3:0] mbreq4, mwdata4, mmode4, mvalid4, mbgrant4, mrdata4, msvalid4;
   logic       brdata4, bsvalid4, bwdata4, bmode4, bvalid4, bbusy4;
   logic [1:0] bmsel4;
   logic [3:0] prev4 = '0;

   bus_arbiter #(.NUM_MASTERS(2), .MSEL_WIDTH(1)) dut2 (
      .clk(clk), .rstn(rstn), .mbreq(mbreq2), .mbgrant(mbgrant2),
      .mwdata(mwdata2), .mmode(mmode2), .mvalid(mvalid2),
      .mrdata(mrdata2), .msvalid(msvalid2), .bwdata(bwdata2),
      .bmode(bmode2), .bvalid(bvalid2), .brdata(brdata2),
      .bsvalid(bsvalid2), .bmsel(bmsel2), .bbusy(bbusy2)
   );

   bus_arbiter #(.NUM_MASTERS(4), .MSEL_WIDTH(2)) dut4 (
      .clk(clk), .rstn(rstn), .mbreq(mbreq4), .mbgrant(mbgrant4),
      .mwdata(mwdata4), .mmode(mmode4), .mvalid(mvalid4),
      .mrdata(mrdata4), .msvalid(msvalid4), .bwdata(bwdata4),
      .bmode(bmode4), .bvalid(bvalid4), .brdata(brdata4),
      .bsvalid(bsvalid4), .bmsel(bmsel4), .bbusy(bbusy4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic goto(input int n);
      do begin
         @(posedge clk);
         #1;
      end while (cyc < n);
   endtask

   task automatic push2(input int idx, input int at);
      q2.push_back('{idx, at});
   endtask

   task automatic push4(input int idx, input int at);
      q4.push_back('{idx, at});
   endtask

   // Monitor: invariants every cycle, scoreboard pop on each new grant.
   always @(negedge clk) begin
      check("onehot2", 32'($onehot0(mbgrant2)), 1);
      check("mux_owner2", 32'(bbusy2 ? mbgrant2[bmsel2] : (mbgrant2 == 2'b00)), 1);
      check("onehot4", 32'($onehot0(mbgrant4)), 1);
      check("mux_owner4", 32'(bbusy4 ? mbgrant4[bmsel4] : (mbgrant4 == 4'b0000)), 1);
      if (mbgrant2 != 2'b00 && mbgrant2 != prev2) begin
         if (q2.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_grant2: got %b required none (cycle %0d)", mbgrant2, cyc);
         end else begin
            e2 = q2.pop_front();
            check("grant2", 32'(mbgrant2), 32'(1 << e2.idx));
            check("grant2_cycle", cyc, e2.cyc);
            check("bmsel2", 32'(bmsel2), e2.idx);
            check("bbusy2", 32'(bbusy2), 1);
         end
      end
      if (mbgrant4 != 4'b0000 && mbgrant4 != prev4) begin
         if (q4.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_grant4: got %b required none (cycle %0d)", mbgrant4, cyc);
         end else begin
            e4 = q4.pop_front();
            check("grant4", 32'(mbgrant4), 32'(1 << e4.idx));
            check("grant4_cycle", cyc, e4.cyc);
            check("bmsel4", 32'(bmsel4), e4.idx);
            check("bbusy4", 32'(bbusy4), 1);
         end
      end
      prev2 <= mbgrant2;
      prev4 <= mbgrant4;
   end

   initial begin
      #100000;
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: got timeout required completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c, d, e, g, m;
      rstn = 1'b0;
      {mbreq2, mwdata2, mmode2, mvalid2, brdata2, bsvalid2} = '0;
      {mbreq4, mwdata4, mmode4, mvalid4, brdata4, bsvalid4} = '0;

      // Reset values
      goto(3);
      @(negedge clk);
      check("rst_grant2", 32'(mbgrant2), 0);
      check("rst_bmsel2", 32'(bmsel2), 0);
      check("rst_bbusy2", 32'(bbusy2), 0);
      check("rst_bus2", 32'({bwdata2, bmode2, bvalid2, mrdata2, msvalid2}), 0);
      check("rst_grant4", 32'(mbgrant4), 0);

      // Single request, grant one cycle later, drop gives dead cycle
      goto(4);
      rstn = 1'b1;
      c = cyc;
      push2(0, c + 1);
      mbreq2 = 2'b01;
      goto(c + 2);
      mbreq2 = 2'b00;
      goto(c + 3);
      @(negedge clk);
      check("release_grant2", 32'(mbgrant2), 0);
      check("release_busy2", 32'(bbusy2), 0);
      goto(c + 5);

      // Reset restores pointer: 11 grants master 0 first
      rstn = 1'b0;
      goto(cyc + 2);
      rstn = 1'b1;
      goto(cyc + 1);
      c = cyc;
      push2(0, c + 1);
      mbreq2 = 2'b11;
      goto(c + 4);
      d = cyc;
      push2(1, d + 3);
      mbreq2 = 2'b10;
      goto(d + 3);
      mwdata2 = 2'b01; mmode2 = 2'b01; mvalid2 = 2'b01;
      @(negedge clk);
      check("mux_m1_zero", 32'({bwdata2, bmode2, bvalid2}), 0);
      check("ret_m1_zero", 32'({mrdata2, msvalid2}), 0);
      goto(d + 4);
      mwdata2 = 2'b10; mmode2 = 2'b10; mvalid2 = 2'b10;
      brdata2 = 1'b1; bsvalid2 = 1'b1;
      @(negedge clk);
      check("mux_m1_one", 32'({bwdata2, bmode2, bvalid2}), 32'h7);
      check("ret_mrdata2", 32'(mrdata2), 32'h2);
      check("ret_msvalid2", 32'(msvalid2), 32'h2);
      goto(d + 5);
      mwdata2 = 2'b01; mvalid2 = 2'b11; brdata2 = 1'b0;
      mbreq2 = 2'b11;
      @(negedge clk);
      check("mux_m1_mixed", 32'({bwdata2, bvalid2}), 32'h1);
      check("ret_mixed2", 32'({mrdata2, msvalid2}), 32'h2);
      goto(d + 7);
      e = cyc;
      push2(0, e + 3);
      mbreq2 = 2'b01;
      goto(e + 1);
      mwdata2 = 2'b11; mmode2 = 2'b11; mvalid2 = 2'b11;
      brdata2 = 1'b1; bsvalid2 = 1'b1;
      @(negedge clk);
      check("dead_mux2", 32'({bwdata2, bmode2, bvalid2}), 0);
      check("dead_ret2", 32'({mrdata2, msvalid2}), 0);
      goto(e + 3);
      @(negedge clk);
      check("m0_ret_mrdata2", 32'(mrdata2), 32'h1);
      goto(e + 5);
      mbreq2 = 2'b00;
      {mwdata2, mmode2, mvalid2, brdata2, bsvalid2} = '0;
      goto(e + 9);

      // Pending request withdrawn before it can be granted
      c = cyc;
      push2(0, c + 1);
      mbreq2 = 2'b01;
      goto(c + 2);
      mbreq2 = 2'b11;
      goto(c + 3);
      mbreq2 = 2'b01;
      goto(c + 5);
      mbreq2 = 2'b00;
      goto(c + 10);
      @(negedge clk);
      check("withdrawn_idle2", 32'({mbgrant2, bbusy2}), 0);

      // Four masters, each holds 10 cycles then re-requests
      rstn = 1'b0;
      goto(cyc + 2);
      rstn = 1'b1;
      c = cyc;
      g = c + 1;
      mbreq4 = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         push4(k, g);
         goto(g + 10);
         mbreq4 = mbreq4 & ~(4'b0001 << k);
         goto(g + 11);
         mbreq4 = mbreq4 | (4'b0001 << k);
         g = g + 13;
      end
      push4(0, g);
      goto(g + 10);
      mbreq4 = 4'b0000;
      goto(g + 14);

      // Reset while master 1 owns the bus
      c = cyc;
      push4(1, c + 1);
      mbreq4 = 4'b0010;
      goto(c + 3);
      mwdata4 = 4'hF; mmode4 = 4'hF; mvalid4 = 4'hF;
      brdata4 = 1'b1; bsvalid4 = 1'b1;
      @(negedge clk);
      check("own_m1_bus4", 32'({bwdata4, bmode4, bvalid4}), 32'h7);
      check("own_m1_ret4", 32'(msvalid4), 32'h2);
      goto(c + 4);
      rstn = 1'b0;
      goto(c + 5);
      @(negedge clk);
      check("midrst_grant4", 32'(mbgrant4), 0);
      check("midrst_bus4", 32'({bwdata4, bmode4, bvalid4, bbusy4}), 0);
      check("midrst_ret4", 32'({mrdata4, msvalid4}), 0);
      check("midrst_bmsel4", 32'(bmsel4), 0);
      goto(c + 6);
      rstn = 1'b1;
      m = cyc;
      push4(3, m + 1);
      mbreq4 = 4'b1000;
      goto(m + 2);
      mbreq4 = 4'b1111;
      goto(m + 4);
      d = cyc;
      push4(0, d + 3);
      mbreq4 = 4'b0111;
      goto(d + 5);
      mbreq4 = 4'b0000;
      {mwdata4, mmode4, mvalid4, brdata4, bsvalid4} = '0;
      goto(d + 9);

      check("sb_drain", 32'(q2.size() + q4.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
